pipeline_hazard_ctrl: RTL

//  Stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Detects load-use hazards and taken branches.
//  - Freezes the pipe while data memory is busy, with a timeout that ends in a sticky error.
//  - Holds the pipe for a fixed number of cycles after reset.

---
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
// Mealy decode of state and hazard inputs; INIT/ERR freeze, memory wait with timeout.
module pipeline_hazard_ctrl #(
    parameter int INIT_CYC = 4,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RD_i,
    input  logic [4:0]       IFID_RS1_i,
    input  logic [4:0]       IFID_RS2_i,
    input  logic             BranchTaken_i,
    input  logic             MemReq_i,
    input  logic             MemReady_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFIDFlush_o,
    output logic             IDEXWrite_o,
    output logic             IDEXBubble_o,
    output logic             EXMEMWrite_o,
    output logic             MEMWBBubble_o,
    output logic             MemErr_o,
    output logic [CNT_W-1:0] StallCnt_o
);

    localparam int CMAX = (INIT_CYC > TIMEOUT) ? INIT_CYC : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_MWAIT = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            mem_err_nxt;
    logic            memstall;
    logic            loaduse;
    logic            active;

    assign memstall = MemReq_i & ~MemReady_i;
    assign loaduse  = IDEX_MemRead_i & (IDEX_RD_i != 5'd0) &
                      ((IDEX_RD_i == IFID_RS1_i) | (IDEX_RD_i == IFID_RS2_i));
    assign active   = (state == S_RUN) | (state == S_MWAIT);

    always_comb begin
        PCWrite_o     = 1'b0;
        IFIDWrite_o   = 1'b0;
        IFIDFlush_o   = 1'b0;
        IDEXWrite_o   = 1'b0;
        IDEXBubble_o  = 1'b1;
        EXMEMWrite_o  = 1'b0;
        MEMWBBubble_o = 1'b1;
        if (active) begin
            PCWrite_o     = 1'b1;
            IFIDWrite_o   = 1'b1;
            IDEXWrite_o   = 1'b1;
            IDEXBubble_o  = 1'b0;
            EXMEMWrite_o  = 1'b1;
            MEMWBBubble_o = 1'b0;
            if (memstall) begin
                PCWrite_o     = 1'b0;
                IFIDWrite_o   = 1'b0;
                IDEXWrite_o   = 1'b0;
                EXMEMWrite_o  = 1'b0;
                MEMWBBubble_o = 1'b1;
            end else if (loaduse) begin
                // branch is ignored here; it re-resolves once the load-use bubble passes
                PCWrite_o    = 1'b0;
                IFIDWrite_o  = 1'b0;
                IDEXBubble_o = 1'b1;
            end else if (BranchTaken_i) begin
                IFIDFlush_o = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mem_err_nxt = MemErr_o;
        case (state)
            S_INIT: begin
                if (cnt == CW'(INIT_CYC - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (memstall) begin
                    cnt_nxt   = CW'(1);
                    state_nxt = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (!memstall) begin
                    cnt_nxt   = '0;
                    state_nxt = S_RUN;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_nxt   = S_ERR;
                    mem_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = S_ERR;
                mem_err_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state      <= S_INIT;
            cnt        <= '0;
            MemErr_o   <= 1'b0;
            StallCnt_o <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            MemErr_o <= mem_err_nxt;
            if (active && !PCWrite_o && (StallCnt_o != {CNT_W{1'b1}})) begin
                StallCnt_o <= StallCnt_o + 1'b1;
            end
        end
    end

endmodule
